bcd_updown_counter_fnd_ctrl: RTL and testbench
==============================================

// Module: bcd_updown_counter_fnd_ctrl
// PURPOSE
//  Parametrised N-digit BCD up/down counter with integrated FND scan driver for the board top.
//  Three debounced buttons (direction toggle, run/pause, clear) control a counter stepped by an internal tick prescaler.
//  Counts directly in BCD (no binary-to-BCD stage) and time-multiplexes DIGITS digits onto one segment bus.
// PARAMETERS
//  DIGITS    4           number of BCD digits / FND commons (1..8)
//  TICK_DIV  62_500_000  clk cycles per count step (0.5 s at 125 MHz); >=2
//  DEBNC_DIV 32_768      clk cycles between button samples; >=2
//  SCAN_DIV  125_000     clk cycles each digit is lit (1 ms at 125 MHz); >=2
// PORTS
//  clk        in   1          system clock, all state on posedge
//  rst        in   1          asynchronous reset, active-low
//  btn_dir    in   1          toggle up/down, active-high, asynchronous raw input
//  btn_run    in   1          toggle run/pause, active-high, raw
//  btn_clr    in   1          clear count to 0, active-high, raw
//  seg_7      out  8          {dp,g,f,e,d,c,b,a}, active-low (common anode)
//  com        out  DIGITS     digit enables, active-low one-hot, com[0] = least significant digit
//  count_bcd  out  4*DIGITS   current count, digit k in [4k+3:4k]
//  up         out  1          1 = counting up
//  running    out  1          1 = counter advancing on ticks
// BEHAVIOUR
//  Reset (rst=0, async): count_bcd=0, up=1, running=1, all prescalers=0, scan index=0,
//   com=all 1s, seg_7=8'hFF; debounce state = released.
//  Input sync: each btn passes through 2 flops before use.
//  Debounce: sample enable every DEBNC_DIV clk; level changes only after 2 consecutive equal samples.
//   Press = rising edge of debounced level -> exactly one 1-clk pulse. Release produces no action.
//  Tick: prescaler counts 0..TICK_DIV-1 while running=1; tick pulse on cycle where value = TICK_DIV-1, then wraps to 0.
//   While paused, prescaler holds its value (no partial-period loss on resume).
//  Step on tick: up=1 -> BCD +1 with ripple carry (digit 9->0, carry into next);
//   up=0 -> BCD -1 with borrow (0->9). Wrap: all-9s +1 -> 0; 0 -1 -> all-9s.
//   count_bcd updates 1 clk after the tick cycle; every digit is always in 0..9.
//  dir pulse: up <= ~up. run pulse: running <= ~running.
//  Simultaneous events in one clk, priority: clr > tick > toggles.
//   clr: count_bcd <= 0 and tick prescaler <= 0; tick in the same clk is discarded.
//   tick + dir pulse: the step uses the old direction; the new direction applies from the next tick.
//   clr does not change up or running.
//  Scan: scan prescaler 0..SCAN_DIV-1; at wrap, digit index advances 0..DIGITS-1, then back to 0.
//   One clk after reset release: com[idx]=0, others=1. seg_7 = decode(count_bcd digit idx), dp=1 (off).
//   com and seg_7 are registered together: no cycle with a new com and stale seg_7.
//   Decode (gfedcba, active-low): 0=7'h40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10.
// CONFIGURATION
//  FND_LEAD_ZERO_BLANK_EN defined: a digit k>0 is blanked (seg_7=8'hFF, com still driven) when it and all
//   higher digits are 0; digit 0 is always shown. count_bcd is unaffected.
//  Undefined: all digits are shown, including leading zeros.
// TESTING (DIGITS=2, TICK_DIV=4, DEBNC_DIV=2, SCAN_DIV=2)
//  Reset, no buttons, 40 clk -> count_bcd steps 00,01,.. one per 4 clk; after 99 -> 00; digits never >9.
//  Press btn_dir (held 10 clk) at count 05 -> up=0 exactly once; counts 04,03,..,00,99; held button = one toggle.
//  Press btn_run -> running=0, count frozen 20 clk; press again -> resumes, first step <=4 clk later.
//  btn_clr pulse aligned with tick cycle at count 37 -> count 00, not 38/01; next step 4 clk after clear.
//  Bounce btn_dir 1-0-1 within 1 sample period -> no toggle; stable 2 samples -> one toggle.
//  Scan check at count 07: com alternates 2'b10/2'b01 every 2 clk; seg_7 = 8'hF8 with com[0]=0;
//   with com[1]=0, seg_7 = 8'hC0, or 8'hFF when FND_LEAD_ZERO_BLANK_EN is defined; mid-run rst -> com=2'b11, seg_7=8'hFF immediately.

Source files
------------

// File: rtl/bcd_updown_counter_fnd_ctrl.sv
// N-digit BCD up/down counter with debounced dir/run/clear buttons and a time-multiplexed FND scan driver.
// Optional build macro FND_LEAD_ZERO_BLANK_EN: blank leading-zero digits on the segment bus.
module bcd_updown_counter_fnd_ctrl #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned TICK_DIV  = 62_500_000,
  parameter int unsigned DEBNC_DIV = 32_768,
  parameter int unsigned SCAN_DIV  = 125_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_dir,
  input  logic                  btn_run,
  input  logic                  btn_clr,
  output logic [7:0]            seg_7,
  output logic [DIGITS-1:0]     com,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  up,
  output logic                  running
);

  localparam int unsigned CNT_W   = 4 * DIGITS;
  localparam int unsigned TICK_W  = $clog2(TICK_DIV);
  localparam int unsigned DEBNC_W = $clog2(DEBNC_DIV);
  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned NBTN    = 3;

  localparam int unsigned BTN_DIR = 0;
  localparam int unsigned BTN_RUN = 1;
  localparam int unsigned BTN_CLR = 2;

  // Active-low gfedcba pattern for one BCD digit
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // One BCD step with ripple carry (inc=1) or borrow (inc=0); wraps at all-9s / all-0s
  function automatic logic [CNT_W-1:0] bcd_step(input logic [CNT_W-1:0] v, input logic inc);
    logic [CNT_W-1:0] r;
    logic             c;
    logic [3:0]       d;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (c) begin
        if (inc) begin
          if (d == 4'd9) begin
            r[4*k +: 4] = 4'd0;
          end else begin
            r[4*k +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*k +: 4] = 4'd9;
          end else begin
            r[4*k +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  logic [NBTN-1:0]    w_btn_raw;
  logic [NBTN-1:0]    r_btn_meta;
  logic [NBTN-1:0]    r_btn_sync;
  logic [NBTN-1:0]    r_btn_smp;
  logic [NBTN-1:0]    r_btn_lvl;
  logic [NBTN-1:0]    r_btn_lvl_d;
  logic [NBTN-1:0]    w_btn_agree;
  logic [NBTN-1:0]    w_press;
  logic [DEBNC_W-1:0] r_debnc_cnt;
  logic               w_debnc_en;

  logic [TICK_W-1:0]  r_tick_cnt;
  logic [TICK_W-1:0]  w_tick_cnt_nxt;
  logic               w_tick;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               r_up;
  logic               w_up_nxt;
  logic               r_running;
  logic               w_running_nxt;

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic               w_scan_wrap;
  logic [IDX_W-1:0]   r_scan_idx;
  logic [3:0]         w_digit;
  logic               w_blank;
  logic [DIGITS-1:0]  w_com_nxt;
  logic [DIGITS-1:0]  r_com;
  logic [7:0]         r_seg;

  assign w_btn_raw = {btn_clr, btn_run, btn_dir};

  // Two-flop synchronisers for the raw asynchronous buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_meta <= '0;
      r_btn_sync <= '0;
    end else begin
      r_btn_meta <= w_btn_raw;
      r_btn_sync <= r_btn_meta;
    end
  end

  assign w_debnc_en  = (r_debnc_cnt == DEBNC_W'(DEBNC_DIV - 1));
  assign w_btn_agree = ~(r_btn_sync ^ r_btn_smp);

  // Debounced level follows the input only after two consecutive equal samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_debnc_cnt <= '0;
      r_btn_smp   <= '0;
      r_btn_lvl   <= '0;
      r_btn_lvl_d <= '0;
    end else begin
      r_debnc_cnt <= w_debnc_en ? '0 : r_debnc_cnt + DEBNC_W'(1);
      r_btn_lvl_d <= r_btn_lvl;
      if (w_debnc_en) begin
        r_btn_smp <= r_btn_sync;
        r_btn_lvl <= (r_btn_lvl & ~w_btn_agree) | (r_btn_sync & w_btn_agree);
      end
    end
  end

  assign w_press = r_btn_lvl & ~r_btn_lvl_d;
  assign w_tick  = r_running && (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  // Counter next state: clear beats tick; toggles act on their own registers
  always_comb begin
    w_count_nxt    = r_count;
    w_tick_cnt_nxt = r_tick_cnt;
    w_up_nxt       = r_up;
    w_running_nxt  = r_running;
    if (w_press[BTN_CLR]) begin
      w_count_nxt    = '0;
      w_tick_cnt_nxt = '0;
    end else begin
      if (r_running) begin
        w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + TICK_W'(1);
      end
      if (w_tick) begin
        w_count_nxt = bcd_step(r_count, r_up);
      end
    end
    if (w_press[BTN_DIR]) begin
      w_up_nxt = ~r_up;
    end
    if (w_press[BTN_RUN]) begin
      w_running_nxt = ~r_running;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      r_count    <= '0;
      r_up       <= 1'b1;
      r_running  <= 1'b1;
    end else begin
      r_tick_cnt <= w_tick_cnt_nxt;
      r_count    <= w_count_nxt;
      r_up       <= w_up_nxt;
      r_running  <= w_running_nxt;
    end
  end

  assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SCAN_W'(1);
      if (w_scan_wrap) begin
        r_scan_idx <= (r_scan_idx == IDX_W'(DIGITS - 1)) ? '0 : r_scan_idx + IDX_W'(1);
      end
    end
  end

  // Select the scanned digit and build its active-low common
  always_comb begin
    w_digit   = 4'd0;
    w_com_nxt = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_scan_idx == IDX_W'(k)) begin
        w_digit      = r_count[4*k +: 4];
        w_com_nxt[k] = 1'b0;
      end
    end
  end

`ifdef FND_LEAD_ZERO_BLANK_EN
  logic w_lz;

  // Blank digit k>0 when it and every higher digit are zero
  always_comb begin
    w_lz    = 1'b1;
    w_blank = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_lz = w_lz & (r_count[4*k +: 4] == 4'd0);
      if ((k != 0) && (r_scan_idx == IDX_W'(k)) && w_lz) begin
        w_blank = 1'b1;
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  // com and seg_7 share one register stage so they always change together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_com <= '1;
      r_seg <= 8'hFF;
    end else begin
      r_com <= w_com_nxt;
      r_seg <= w_blank ? 8'hFF : {1'b1, seg7_decode(w_digit)};
    end
  end

  assign seg_7     = r_seg;
  assign com       = r_com;
  assign count_bcd = r_count;
  assign up        = r_up;
  assign running   = r_running;

endmodule

// File: tb/tb_bcd_updown_counter_fnd_ctrl.sv
// Directed bench for bcd_updown_counter_fnd_ctrl (DIGITS=2, TICK_DIV=4, DEBNC_DIV=2, SCAN_DIV=2).
// Expected values are hand-derived cycle by cycle, counted in posedges since reset release.
module tb_bcd_updown_counter_fnd_ctrl;

`ifdef FND_LEAD_ZERO_BLANK_EN
  localparam logic [7:0] SEG_LZ = 8'hFF;
`else
  localparam logic [7:0] SEG_LZ = 8'hC0;
`endif

  logic       clk;
  logic       rst;
  logic       btn_dir;
  logic       btn_run;
  logic       btn_clr;
  logic [7:0] seg_7;
  logic [1:0] com;
  logic [7:0] count_bcd;
  logic       up;
  logic       running;

  int n_checks;
  int n_errors;
  int cyc;
  int bad_digits;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic       up;
    logic       run;
    logic [2:0] btn;   // {clr, run, dir} driven after this check
    logic       chk_scan;
    logic [1:0] com;
    logic [7:0] seg;
  } vec_t;

  vec_t tbl[$];

  bcd_updown_counter_fnd_ctrl #(
    .DIGITS(2), .TICK_DIV(4), .DEBNC_DIV(2), .SCAN_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .btn_dir(btn_dir), .btn_run(btn_run), .btn_clr(btn_clr),
    .seg_7(seg_7), .com(com), .count_bcd(count_bcd), .up(up), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Every digit must stay a legal BCD value
  always @(negedge clk) begin
    if (rst) begin
      if (count_bcd[3:0] > 4'd9 || count_bcd[7:4] > 4'd9) bad_digits <= bad_digits + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, act, want);
    end
  endtask

  function automatic void e(input int c, input logic [7:0] cnt, input logic u, input logic r,
                            input logic [2:0] b);
    vec_t v;
    v.cyc = c; v.cnt = cnt; v.up = u; v.run = r; v.btn = b;
    v.chk_scan = 1'b0; v.com = 2'b11; v.seg = 8'hFF;
    tbl.push_back(v);
  endfunction

  function automatic void es(input int c, input logic [7:0] cnt, input logic [1:0] cm,
                             input logic [7:0] sg);
    vec_t v;
    v.cyc = c; v.cnt = cnt; v.up = 1'b1; v.run = 1'b1; v.btn = 3'b000;
    v.chk_scan = 1'b1; v.com = cm; v.seg = sg;
    tbl.push_back(v);
  endfunction

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    bad_digits = 0;
    rst        = 1'b0;
    btn_dir    = 1'b0;
    btn_run    = 1'b0;
    btn_clr    = 1'b0;

    // Free run from reset, scan decode of every digit value, up wrap 99 -> 00
    es(0, 8'h00, 2'b11, 8'hFF);
    es(1, 8'h00, 2'b10, 8'hC0);
    es(3, 8'h00, 2'b01, SEG_LZ);
    e(4, 8'h01, 1, 1, 3'b000);
    es(5, 8'h01, 2'b10, 8'hF9);
    es(9, 8'h02, 2'b10, 8'hA4);
    es(13, 8'h03, 2'b10, 8'hB0);
    es(17, 8'h04, 2'b10, 8'h99);
    es(21, 8'h05, 2'b10, 8'h92);
    es(25, 8'h06, 2'b10, 8'h82);
    es(29, 8'h07, 2'b10, 8'hF8);
    es(33, 8'h08, 2'b10, 8'h80);
    es(37, 8'h09, 2'b10, 8'h90);
    e(40, 8'h10, 1, 1, 3'b000);
    es(43, 8'h10, 2'b01, 8'hF9);
    es(83, 8'h20, 2'b01, 8'hA4);
    e(396, 8'h99, 1, 1, 3'b000);
    e(399, 8'h99, 1, 1, 3'b000);
    e(400, 8'h00, 1, 1, 3'b000);
    e(404, 8'h01, 1, 1, 3'b000);
    // Direction press at 05, held 10 clk: one toggle, then down through 00 -> 99
    e(420, 8'h05, 1, 1, 3'b001);
    e(422, 8'h05, 1, 1, 3'b001);
    e(424, 8'h06, 1, 1, 3'b001);
    e(428, 8'h05, 0, 1, 3'b001);
    e(430, 8'h05, 0, 1, 3'b000);
    e(432, 8'h04, 0, 1, 3'b000);
    e(448, 8'h00, 0, 1, 3'b000);
    e(452, 8'h99, 0, 1, 3'b000);
    e(456, 8'h98, 0, 1, 3'b000);
    // Pause, frozen count, resume with prescaler phase preserved
    e(457, 8'h98, 0, 1, 3'b010);
    e(460, 8'h97, 0, 1, 3'b010);
    e(462, 8'h97, 0, 1, 3'b010);
    e(463, 8'h97, 0, 0, 3'b010);
    e(465, 8'h97, 0, 0, 3'b010);
    e(467, 8'h97, 0, 0, 3'b000);
    e(485, 8'h97, 0, 0, 3'b010);
    e(490, 8'h97, 0, 0, 3'b010);
    e(491, 8'h97, 0, 1, 3'b010);
    e(492, 8'h96, 0, 1, 3'b010);
    e(495, 8'h96, 0, 1, 3'b000);
    // Plain clear: also restarts the tick prescaler
    e(496, 8'h95, 0, 1, 3'b100);
    e(500, 8'h94, 0, 1, 3'b100);
    e(502, 8'h94, 0, 1, 3'b100);
    e(503, 8'h00, 0, 1, 3'b100);
    e(506, 8'h00, 0, 1, 3'b000);
    e(507, 8'h99, 0, 1, 3'b000);
    e(511, 8'h98, 0, 1, 3'b000);
    // Clear landing on the tick cycle at 37: tick discarded
    e(751, 8'h38, 0, 1, 3'b000);
    e(753, 8'h38, 0, 1, 3'b100);
    e(755, 8'h37, 0, 1, 3'b100);
    e(758, 8'h37, 0, 1, 3'b100);
    e(759, 8'h00, 0, 1, 3'b100);
    e(762, 8'h00, 0, 1, 3'b100);
    e(763, 8'h99, 0, 1, 3'b000);
    // Bounce seen by a single sample only: no toggle
    e(765, 8'h99, 0, 1, 3'b001);
    e(766, 8'h99, 0, 1, 3'b000);
    e(767, 8'h98, 0, 1, 3'b000);
    e(768, 8'h98, 0, 1, 3'b001);
    e(769, 8'h98, 0, 1, 3'b000);
    e(776, 8'h96, 0, 1, 3'b000);
    // Stable press: toggle lands on a tick, step still uses the old direction
    e(777, 8'h96, 0, 1, 3'b001);
    e(779, 8'h95, 0, 1, 3'b001);
    e(782, 8'h95, 0, 1, 3'b001);
    e(783, 8'h94, 1, 1, 3'b001);
    e(787, 8'h95, 1, 1, 3'b000);
    e(791, 8'h96, 1, 1, 3'b000);
    // Scan at count 07
    es(836, 8'h07, 2'b01, SEG_LZ);
    es(837, 8'h07, 2'b10, 8'hF8);
    es(838, 8'h07, 2'b10, 8'hF8);
    es(839, 8'h08, 2'b01, SEG_LZ);

    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      while (cyc < tbl[i].cyc) @(negedge clk);
      chk("count_bcd", cyc, 32'(count_bcd), 32'(tbl[i].cnt));
      chk("up", cyc, 32'(up), 32'(tbl[i].up));
      chk("running", cyc, 32'(running), 32'(tbl[i].run));
      if (tbl[i].chk_scan) begin
        chk("com", cyc, 32'(com), 32'(tbl[i].com));
        chk("seg_7", cyc, 32'(seg_7), 32'(tbl[i].seg));
      end
      {btn_clr, btn_run, btn_dir} = tbl[i].btn;
    end

    // Mid-cycle asynchronous reset takes effect immediately
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_com", cyc, 32'(com), 32'h3);
    chk("rst_seg", cyc, 32'(seg_7), 32'hFF);
    chk("rst_count", cyc, 32'(count_bcd), 32'h0);
    chk("rst_up", cyc, 32'(up), 32'h1);
    chk("rst_running", cyc, 32'(running), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_com", cyc, 32'(com), 32'h2);
    chk("rel_seg", cyc, 32'(seg_7), 32'hC0);
    repeat (3) @(negedge clk);
    chk("rel_count", cyc, 32'(count_bcd), 32'h01);

    chk("digit_range", cyc, 32'(bad_digits), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
